// File: rtl/tri_aoi22_nlat_skid2.sv
//==============================================================================
//  Module      : tri_aoi22_nlat_skid2
//  Description : Two-entry skid buffer behind an aoi22 nlat stage. Takes the
//                inverted-polarity qb bus, restores true polarity (optional)
//                and presents it downstream with a valid/ready handshake.
//                The aoi22 stage can run every cycle while the consumer stalls.
//                Clock gating follows the trilib LCB model:
//                en = (act | force_t) & thold_b.
//
//  Ports
//    nclk     in    nclk[0] clock (posedge), nclk[1] synchronous sreset
//    vd, gd   inout power pins, unused
//    act      in    functional clock enable
//    force_t  in    force LCB active
//    thold_b  in    1: clocks run, 0: hold all state
//    scin     in    scan in, unused
//    scout    out   scan out, tied 0
//    in_val   in    upstream qb bus valid
//    in_qb    in    upstream data, inverted polarity
//    in_rdy   out   buffer can accept this cycle
//    out_val  out   out_d holds valid data
//    out_d    out   head entry, true polarity
//    out_rdy  in    consumer accepts this cycle
//    occ      out   entry count 0..2
//
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tri_aoi22_nlat_skid2 #(
    parameter int                 WIDTH        = 4,
    parameter int                 OFFSET       = 0,
    parameter logic [WIDTH-1:0]   INIT         = '0,
    parameter int                 INVERT       = 1,
    parameter int                 NEEDS_SRESET = 1
) (
    input  logic [0:`NCLK_WIDTH-1]          nclk,
    inout  wire                             vd,
    inout  wire                             gd,
    input  logic                            act,
    input  logic                            force_t,
    input  logic                            thold_b,
    input  logic [OFFSET:OFFSET+WIDTH-1]    scin,
    output logic [OFFSET:OFFSET+WIDTH-1]    scout,
    input  logic                            in_val,
    input  logic [OFFSET:OFFSET+WIDTH-1]    in_qb,
    output logic                            in_rdy,
    output logic                            out_val,
    output logic [OFFSET:OFFSET+WIDTH-1]    out_d,
    input  logic                            out_rdy,
    output logic [1:0]                      occ
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam logic [1:0] S_EMPTY = 2'd0;   // no entries
    localparam logic [1:0] S_ONE   = 2'd1;   // head valid
    localparam logic [1:0] S_FULL  = 2'd2;   // head and skid valid

    localparam bit c_sreset = (NEEDS_SRESET != 0);

    //--------------------------------------------------------------------------
    // Declarations
    //--------------------------------------------------------------------------
    logic                 w_rst;
    logic                 w_en;
    logic                 w_push;
    logic                 w_pop;
    logic [0:WIDTH-1]     w_wdata;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;

    logic                 w_in_rdy;
    logic                 w_out_val;
    logic                 w_ld_head_in;
    logic                 w_ld_head_skid;
    logic                 w_ld_skid_in;

    logic [0:WIDTH-1]     r_head;
    logic [0:WIDTH-1]     r_skid;

    // Power pins, scan-in and spare nclk bits have no function in this model.
    wire w_unused = ^{vd, gd, scin, nclk};

    //--------------------------------------------------------------------------
    // LCB: functional enable and synchronous reset
    //--------------------------------------------------------------------------
    assign w_rst = nclk[1];
    assign w_en  = (act | force_t) & thold_b;

    // Handshake qualification. The ready/valid outputs depend only on the
    // registered state, the LCB enable and reset, so push and pop never form
    // a combinational path from in_val to out_val or from out_rdy to in_rdy.
    assign w_push = in_val  & w_in_rdy;
    assign w_pop  = w_out_val & out_rdy;

    //--------------------------------------------------------------------------
    // Write-data polarity
    //--------------------------------------------------------------------------
    generate
        if (INVERT != 0) begin : g_invert
            assign w_wdata = ~in_qb;
        end else begin : g_passthru
            assign w_wdata = in_qb;
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Occupancy FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge nclk[0]) begin
        if (w_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Occupancy FSM: next-state logic. With en low push and pop are both
    // zero, so every state simply holds.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && !w_pop) begin
                    w_state_nxt = S_FULL;
                end else if (!w_push && w_pop) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_state_nxt = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Occupancy FSM: outputs and datapath load controls
    //--------------------------------------------------------------------------
    always_comb begin
        w_in_rdy       = 1'b0;
        w_out_val      = 1'b0;
        w_ld_head_in   = 1'b0;
        w_ld_head_skid = 1'b0;
        w_ld_skid_in   = 1'b0;

        // Reset discards everything, so nothing is offered or accepted in
        // the reset cycle even if the old state was non-empty.
        if (w_en && !w_rst) begin
            w_in_rdy  = (r_state != S_FULL);
            w_out_val = (r_state != S_EMPTY);
        end

        case (r_state)
            S_EMPTY: begin
                w_ld_head_in = w_push;
            end
            S_ONE: begin
                // Simultaneous push and pop replaces the head in place; the
                // skid entry is only used when the consumer stalls.
                w_ld_head_in = w_push & w_pop;
                w_ld_skid_in = w_push & ~w_pop;
            end
            S_FULL: begin
                w_ld_head_skid = w_pop;
            end
            default: begin
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Storage. Entries not being loaded keep their last value; the head is
    // stale (but stable) while the buffer is empty.
    //--------------------------------------------------------------------------
    always_ff @(posedge nclk[0]) begin
        if (w_rst) begin
            if (c_sreset) begin
                r_head <= INIT;
                r_skid <= INIT;
            end
        end else begin
            if (w_ld_head_in) begin
                r_head <= w_wdata;
            end else if (w_ld_head_skid) begin
                r_head <= r_skid;
            end
            if (w_ld_skid_in) begin
                r_skid <= w_wdata;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign in_rdy  = w_in_rdy;
    assign out_val = w_out_val;
    assign out_d   = r_head;
    assign occ     = r_state;
    assign scout   = '0;

endmodule

`default_nettype wire

// File: tb/tb_tri_aoi22_nlat_skid2.sv
//==============================================================================
//  Module      : tb_tri_aoi22_nlat_skid2
//  Description : Self-checking bench for tri_aoi22_nlat_skid2. A table of
//                per-cycle input/expected-output records drives an inverting
//                instance (INIT=4'h5) and a non-inverting instance (INIT=4'h0)
//                in parallel, followed by hand-written reset sequences.
//  Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tb_tri_aoi22_nlat_skid2;

    typedef struct {
        logic       rst;
        logic       act;
        logic       frc;
        logic       thb;
        logic       iv;
        logic [3:0] qb;
        logic       ordy;
        logic [1:0] e_occ;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_d;
        logic       chk_d;
    } vec_t;

    logic                    clk;
    logic                    sreset;
    logic [0:`NCLK_WIDTH-1]  nclk;
    wire                     vd = 1'b1;
    wire                     gd = 1'b0;
    logic                    act;
    logic                    force_t;
    logic                    thold_b;
    logic [3:0]              scin;
    logic                    in_val;
    logic [3:0]              in_qb;
    logic                    out_rdy;

    logic [3:0]              scout;
    logic                    in_rdy;
    logic                    out_val;
    logic [3:0]              out_d;
    logic [1:0]              occ;

    logic [3:0]              scout_n;
    logic                    in_rdy_n;
    logic                    out_val_n;
    logic [3:0]              out_d_n;
    logic [1:0]              occ_n;

    int n_chk;
    int n_fail;

    always_comb begin
        nclk    = '0;
        nclk[0] = clk;
        nclk[1] = sreset;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tri_aoi22_nlat_skid2 #(
        .WIDTH(4), .OFFSET(0), .INIT(4'h5), .INVERT(1), .NEEDS_SRESET(1)
    ) dut (
        .nclk(nclk), .vd(vd), .gd(gd), .act(act), .force_t(force_t),
        .thold_b(thold_b), .scin(scin), .scout(scout),
        .in_val(in_val), .in_qb(in_qb), .in_rdy(in_rdy),
        .out_val(out_val), .out_d(out_d), .out_rdy(out_rdy), .occ(occ)
    );

    tri_aoi22_nlat_skid2 #(
        .WIDTH(4), .OFFSET(0), .INIT(4'h0), .INVERT(0), .NEEDS_SRESET(1)
    ) dut_ni (
        .nclk(nclk), .vd(vd), .gd(gd), .act(act), .force_t(force_t),
        .thold_b(thold_b), .scin(scin), .scout(scout_n),
        .in_val(in_val), .in_qb(in_qb), .in_rdy(in_rdy_n),
        .out_val(out_val_n), .out_d(out_d_n), .out_rdy(out_rdy), .occ(occ_n)
    );

    task automatic chk(input string name, input int idx, input int act_v, input int exp_v);
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act_v, exp_v);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic a, input logic f,
                                input logic t, input logic iv, input logic [3:0] qb,
                                input logic ordy, input logic [1:0] eocc,
                                input logic eir, input logic eov,
                                input logic [3:0] ed, input logic cd);
        vec_t v;
        v.rst = rst; v.act = a; v.frc = f; v.thb = t; v.iv = iv; v.qb = qb;
        v.ordy = ordy; v.e_occ = eocc; v.e_ir = eir; v.e_ov = eov;
        v.e_d = ed; v.chk_d = cd;
        return v;
    endfunction

    // Watchdog: the bench uses fixed cycle counts, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[20];

        n_chk  = 0;
        n_fail = 0;

        //        rst act frc thb iv  qb     ordy  occ ir ov  d      chk_d
        vt[0]  = mk(0, 1, 0, 1, 0, 4'h0, 0,   0, 1, 0, 4'h5, 1); // reset state
        vt[1]  = mk(0, 1, 0, 1, 1, 4'hC, 1,   0, 1, 0, 4'h5, 1); // push C
        vt[2]  = mk(0, 1, 0, 1, 0, 4'h0, 1,   1, 1, 1, 4'h3, 1); // ~C, pop
        vt[3]  = mk(0, 1, 0, 1, 1, 4'hE, 0,   0, 1, 0, 4'h0, 0); // push E
        vt[4]  = mk(0, 1, 0, 1, 1, 4'hD, 0,   1, 1, 1, 4'h1, 1); // push D
        vt[5]  = mk(0, 1, 0, 1, 1, 4'h7, 0,   2, 0, 1, 4'h1, 1); // full, push blocked
        vt[6]  = mk(0, 1, 0, 1, 0, 4'h0, 1,   2, 0, 1, 4'h1, 1); // pop 1
        vt[7]  = mk(0, 1, 0, 1, 0, 4'h0, 1,   1, 1, 1, 4'h2, 1); // pop 2
        vt[8]  = mk(0, 1, 0, 1, 1, 4'hA, 0,   0, 1, 0, 4'h0, 0); // push A
        vt[9]  = mk(0, 1, 0, 1, 1, 4'h0, 1,   1, 1, 1, 4'h5, 1); // push 0 + pop
        vt[10] = mk(0, 1, 0, 1, 1, 4'h9, 0,   1, 1, 1, 4'hF, 1); // push 9
        vt[11] = mk(0, 1, 0, 0, 1, 4'h3, 1,   2, 0, 0, 4'hF, 1); // thold low
        vt[12] = mk(0, 1, 1, 0, 1, 4'h3, 1,   2, 0, 0, 4'hF, 1); // force, thold low
        vt[13] = mk(0, 0, 1, 1, 0, 4'h0, 1,   2, 0, 1, 4'hF, 1); // force only, pop
        vt[14] = mk(0, 1, 0, 1, 0, 4'h0, 1,   1, 1, 1, 4'h6, 1); // pop 6
        vt[15] = mk(0, 0, 0, 1, 1, 4'h1, 0,   0, 0, 0, 4'h0, 0); // act low
        vt[16] = mk(0, 1, 0, 1, 1, 4'h2, 0,   0, 1, 0, 4'h0, 0); // push 2
        vt[17] = mk(0, 1, 0, 1, 1, 4'h3, 0,   1, 1, 1, 4'hD, 1); // push 3
        vt[18] = mk(1, 1, 0, 1, 1, 4'h4, 1,   2, 0, 0, 4'hD, 1); // reset while full
        vt[19] = mk(0, 1, 0, 1, 0, 4'h0, 0,   0, 1, 0, 4'h5, 1); // after reset

        act = 1'b1; force_t = 1'b0; thold_b = 1'b1; scin = 4'h0;
        in_val = 1'b0; in_qb = 4'h0; out_rdy = 1'b0;
        sreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            sreset  = vt[i].rst;
            act     = vt[i].act;
            force_t = vt[i].frc;
            thold_b = vt[i].thb;
            in_val  = vt[i].iv;
            in_qb   = vt[i].qb;
            out_rdy = vt[i].ordy;
            #1;
            chk("occ",     i, int'(occ),     int'(vt[i].e_occ));
            chk("in_rdy",  i, int'(in_rdy),  int'(vt[i].e_ir));
            chk("out_val", i, int'(out_val), int'(vt[i].e_ov));
            chk("occ_ni",  i, int'(occ_n),   int'(vt[i].e_occ));
            if (vt[i].chk_d) begin
                chk("out_d", i, int'(out_d), int'(vt[i].e_d));
            end
            @(posedge clk);
            #1;
        end

        // Polarity: same push into both instances.
        sreset = 1'b0; act = 1'b1; force_t = 1'b0; thold_b = 1'b1;
        in_val = 1'b1; in_qb = 4'hA; out_rdy = 1'b0;
        @(posedge clk);
        #1;
        in_val = 1'b0;
        #1;
        chk("pol_out_d_inv",   100, int'(out_d),     4'h5);
        chk("pol_out_d_ninv",  100, int'(out_d_n),   4'hA);
        chk("pol_out_val_ni",  100, int'(out_val_n), 1);
        chk("scout",           100, int'(scout),     0);

        // Reset with a push and pop pending: both are ignored.
        sreset = 1'b1; in_val = 1'b1; in_qb = 4'h3; out_rdy = 1'b1;
        @(posedge clk);
        #1;
        sreset = 1'b0; in_val = 1'b0; out_rdy = 1'b0;
        #1;
        chk("rst_occ",      101, int'(occ),     0);
        chk("rst_out_d",    101, int'(out_d),   4'h5);
        chk("rst_out_d_ni", 101, int'(out_d_n), 4'h0);
        chk("rst_in_rdy",   101, int'(in_rdy),  1);
        @(posedge clk);
        #2;
        chk("rst_idle_occ",    102, int'(occ),     0);
        chk("rst_idle_outval", 102, int'(out_val), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
